// File: rtl/decoder_3to8.sv
// ---------------------------------------------------------------------------
// decoder_3to8
//
// Registered binary-to-one-hot select decoder. A select code on `in` is
// decoded into one of OUT_W select lines when `enable` is high; with enable
// low every line is inactive. The result is registered, so `out` changes only
// on a rising clock edge and lags its inputs by exactly one cycle.
//
// Reset (rst_n low) clears the outputs to the inactive level immediately,
// without waiting for a clock edge. Release is taken on the next rising edge.
//
// OUT_ACTIVE_LOW = 1 inverts every output line, including the reset value,
// for downstream selects that are active low.
//
// Optional build macro: DECODER_3TO8_STATUS_EN
//   Adds out_valid (registered enable) and sel_q (last enabled select code).
//   The behaviour of `out` is the same with or without the macro.
// ---------------------------------------------------------------------------
module decoder_3to8 #(
    parameter int IN_W           = 3,
    parameter int OUT_W          = 8,
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic             enable,
    output logic [OUT_W-1:0] out
`ifdef DECODER_3TO8_STATUS_EN
    ,
    output logic             out_valid,
    output logic [IN_W-1:0]  sel_q
`endif
);

    // Level driven on a select line that is not selected (and during reset).
    localparam logic INACTIVE_LVL = OUT_ACTIVE_LOW;

    // -----------------------------------------------------------------------
    // Configuration guard: one output line per select code, no more, no less.
    // A mismatched pair would silently drop or never drive some selects.
    // -----------------------------------------------------------------------
    generate
        if (OUT_W != (1 << IN_W)) begin : g_bad_cfg
            $error("decoder_3to8: OUT_W (%0d) must equal 2**IN_W (%0d)",
                   OUT_W, (1 << IN_W));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state decode, active-high form.
    //
    // The select is written by indexing with `in`. If `in` carries X/Z the
    // indexed write is dropped in simulation and, likewise, an unknown
    // `enable` takes the "not enabled" branch, so an undefined input decodes
    // to all-inactive rather than a partial one-hot pattern.
    // -----------------------------------------------------------------------
    logic [OUT_W-1:0] decode_next;

    // Combinational one-hot decode of the current select code.
    always_comb begin
        decode_next = '0;
        if (enable) begin
            decode_next[in] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output register, one flop per select line. The polarity inversion is
    // folded in ahead of the flop so nothing combinational follows it and the
    // outputs come straight from registers.
    // -----------------------------------------------------------------------
    logic [OUT_W-1:0] out_reg;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_line
            // Register select line gi; async clear to the inactive level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg[gi] <= INACTIVE_LVL;
                end else begin
                    out_reg[gi] <= decode_next[gi] ^ OUT_ACTIVE_LOW;
                end
            end
        end
    endgenerate

    assign out = out_reg;

`ifdef DECODER_3TO8_STATUS_EN
    // -----------------------------------------------------------------------
    // Status side-band. out_valid follows enable with the same latency as
    // out; sel_q remembers the last code that was actually decoded, so it
    // holds through disabled cycles.
    // -----------------------------------------------------------------------
    logic            valid_reg;
    logic [IN_W-1:0] sel_reg;

    // Register enable and capture the select code only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            sel_reg   <= '0;
        end else begin
            valid_reg <= enable;
            if (enable) begin
                sel_reg <= in;
            end
        end
    end

    assign out_valid = valid_reg;
    assign sel_q     = sel_reg;
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// ---------------------------------------------------------------------------
// tb_decoder_3to8
//
// Directed testbench for decoder_3to8 (default polarity). Inputs change on
// the falling edge; outputs are sampled 1 ns after the rising edge or at
// chosen points between edges. Define DECODER_3TO8_STATUS_EN to also cover
// the status outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_3to8;

    logic       clk;
    logic       rst_n;
    logic [2:0] in;
    logic       enable;
    logic [7:0] out;
`ifdef DECODER_3TO8_STATUS_EN
    logic       out_valid;
    logic [2:0] sel_q;
`endif

    int n_cmp;
    int n_bad;

    // Hand-written expected one-hot patterns for select codes 0..7.
    logic [7:0] exp_tab [8];

    decoder_3to8 #(
        .IN_W           (3),
        .OUT_W          (8),
        .OUT_ACTIVE_LOW (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .enable    (enable),
        .out       (out)
`ifdef DECODER_3TO8_STATUS_EN
        ,
        .out_valid (out_valid),
        .sel_q     (sel_q)
`endif
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ns ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log it.
    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end else begin
            $display("ok   %s: %b", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where inputs are changed.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_tab[0] = 8'b0000_0001;
        exp_tab[1] = 8'b0000_0010;
        exp_tab[2] = 8'b0000_0100;
        exp_tab[3] = 8'b0000_1000;
        exp_tab[4] = 8'b0001_0000;
        exp_tab[5] = 8'b0010_0000;
        exp_tab[6] = 8'b0100_0000;
        exp_tab[7] = 8'b1000_0000;

        // ---- Reset held with an active decode request on the inputs ----
        rst_n  = 1'b0;
        in     = 3'b101;
        enable = 1'b1;
        #1;
        check_eq("reset_initial", out, 8'b0000_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("reset_hold_edge%0d", k), out, 8'b0000_0000);
        end

        // ---- Release: first rising edge afterwards decodes 101 ----
        to_negedge();
        rst_n = 1'b1;
        #1;
        check_eq("release_before_edge", out, 8'b0000_0000);
        tick();
        check_eq("release_first_edge", out, 8'b0010_0000);

        // ---- Exhaustive sweep with lag and one-hot checks ----
        for (int i = 0; i < 8; i++) begin
            logic [7:0] prev;
            prev = out;
            to_negedge();
            in     = 3'(i);
            enable = 1'b1;
            #1;
            check_eq($sformatf("sweep_lag_in%0d", i), out, prev);
            tick();
            check_eq($sformatf("sweep_in%0d", i), out, exp_tab[i]);
            check_eq($sformatf("sweep_onehot_in%0d", i),
                     8'($countones(out)), 8'd1);
        end

        // ---- Disable ----
        to_negedge();
        in = 3'b001; enable = 1'b0;
        tick();
        check_eq("disable_in001", out, 8'b0000_0000);
        to_negedge();
        in = 3'b010; enable = 1'b0;
        tick();
        check_eq("disable_in010", out, 8'b0000_0000);
        to_negedge();
        in = 3'b010; enable = 1'b1;
        tick();
        check_eq("reenable_in010", out, 8'b0000_0100);

        // ---- Between-edge glitch on `in` ----
        to_negedge();
        in = 3'b011; enable = 1'b1;
        tick();
        check_eq("glitch_base", out, 8'b0000_1000);
        #1 in = 3'b110;
        #2;
        check_eq("glitch_in110", out, 8'b0000_1000);
        in = 3'b011;
        #1;
        check_eq("glitch_back011", out, 8'b0000_1000);
        tick();
        check_eq("glitch_next_edge", out, 8'b0000_1000);

        // ---- Asynchronous reset mid-stream ----
        to_negedge();
        in = 3'b111; enable = 1'b1;
        tick();
        check_eq("async_pre", out, 8'b1000_0000);
        to_negedge();
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_clear_no_clk", out, 8'b0000_0000);
        in = 3'b000; enable = 1'b1;
        #1 rst_n = 1'b1;
        #1;
        check_eq("async_release_hold", out, 8'b0000_0000);
        tick();
        check_eq("async_release_edge", out, 8'b0000_0001);

`ifdef DECODER_3TO8_STATUS_EN
        // ---- Status outputs ----
        to_negedge();
        in = 3'b110; enable = 1'b1;
        tick();
        check_eq("status_out", out, 8'b0100_0000);
        check_eq("status_valid_hi", {7'd0, out_valid}, 8'd1);
        check_eq("status_sel_110", {5'd0, sel_q}, 8'd6);
        to_negedge();
        in = 3'b011; enable = 1'b0;
        tick();
        check_eq("status_out_off", out, 8'b0000_0000);
        check_eq("status_valid_lo", {7'd0, out_valid}, 8'd0);
        check_eq("status_sel_held", {5'd0, sel_q}, 8'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
